wb_stage: RTL and testbench

Writeback stage of the five-stage RISC-V pipeline: the producer side of the register bank's write port. It latches the MEM/WB pipeline fields on the rising edge and aligns and extends load data. It selects the writeback source and drives RegWEn/AddrD/DataD, which the register bank commits on the following falling edge. It also keeps a retired-instruction counter for performance and verification use.

---
 rtl/wb_stage_if.sv | 36 +++
 rtl/wb_stage.sv | 116 +++++++++++
 tb/tb_wb_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline bus plus the register-bank write port driven by the writeback stage.
interface wb_stage_if #(
  parameter int unsigned WIDTH_ADDR_LENGTH = 5,
  parameter int unsigned WIDTH_DATA_LENGTH = 32
);
  logic                         Stall;
  logic                         Flush;
  logic                         MemValid;
  logic                         MemRegWEn;
  logic [WIDTH_ADDR_LENGTH-1:0] MemAddrD;
  logic [1:0]                   MemWBSel;
  logic [2:0]                   MemFunct3;
  logic [1:0]                   MemByteOff;
  logic [WIDTH_DATA_LENGTH-1:0] MemALUOut;
  logic [WIDTH_DATA_LENGTH-1:0] MemLoadData;
  logic [WIDTH_DATA_LENGTH-1:0] MemPC;
  logic                         RegWEn;
  logic [WIDTH_ADDR_LENGTH-1:0] AddrD;
  logic [WIDTH_DATA_LENGTH-1:0] DataD;
  logic                         WbValid;
  logic [WIDTH_DATA_LENGTH-1:0] RetireCount;

  // Upstream pipeline / environment side
  modport master (
    output Stall, Flush, MemValid, MemRegWEn, MemAddrD, MemWBSel, MemFunct3,
           MemByteOff, MemALUOut, MemLoadData, MemPC,
    input  RegWEn, AddrD, DataD, WbValid, RetireCount
  );

  // Writeback stage side
  modport slave (
    input  Stall, Flush, MemValid, MemRegWEn, MemAddrD, MemWBSel, MemFunct3,
           MemByteOff, MemALUOut, MemLoadData, MemPC,
    output RegWEn, AddrD, DataD, WbValid, RetireCount
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: latches MEM/WB fields, aligns/extends load data, selects the
// writeback source and drives the register-bank write port. Also counts retired
// instructions.
module wb_stage #(
  parameter int unsigned WIDTH_ADDR_LENGTH = 5,
  parameter int unsigned WIDTH_DATA_LENGTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  wb_stage_if.slave bus
);

  localparam int unsigned AW = WIDTH_ADDR_LENGTH;
  localparam int unsigned DW = WIDTH_DATA_LENGTH;

  localparam logic [1:0] WBSEL_LOAD = 2'd0;
  localparam logic [1:0] WBSEL_ALU  = 2'd1;
  localparam logic [1:0] WBSEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic          r_valid;
  logic          r_regwen;
  logic [AW-1:0] r_addrd;
  logic [1:0]    r_wbsel;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_load;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_retire_count;

  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_load_aligned;
  logic [DW-1:0] w_data;

  // Stage registers: flush inserts a bubble (wins over stall), stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_regwen <= 1'b0;
      r_addrd  <= '0;
      r_wbsel  <= '0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_alu    <= '0;
      r_load   <= '0;
      r_pc     <= '0;
    end else if (bus.Flush) begin
      r_valid <= 1'b0;
    end else if (!bus.Stall) begin
      r_valid  <= bus.MemValid;
      r_regwen <= bus.MemRegWEn;
      r_addrd  <= bus.MemAddrD;
      r_wbsel  <= bus.MemWBSel;
      r_funct3 <= bus.MemFunct3;
      r_off    <= bus.MemByteOff;
      r_alu    <= bus.MemALUOut;
      r_load   <= bus.MemLoadData;
      r_pc     <= bus.MemPC;
    end
  end

  // Retired-instruction counter: counts valid instructions entering the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_count <= '0;
    end else if (!bus.Flush && !bus.Stall && bus.MemValid) begin
      r_retire_count <= r_retire_count + DW'(1);
    end
  end

  // Load alignment and sign/zero extension from the captured word
  always_comb begin
    w_byte         = r_load[7:0];
    w_half         = r_load[15:0];
    w_load_aligned = r_load;
    case (r_off)
      2'd0:    w_byte = r_load[7:0];
      2'd1:    w_byte = r_load[15:8];
      2'd2:    w_byte = r_load[23:16];
      default: w_byte = r_load[31:24];
    endcase
    w_half = r_off[1] ? r_load[31:16] : r_load[15:0];
    case (r_funct3)
      F3_LB:   w_load_aligned = {{(DW-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_load_aligned = {{(DW-8){1'b0}}, w_byte};
      F3_LH:   w_load_aligned = {{(DW-16){w_half[15]}}, w_half};
      F3_LHU:  w_load_aligned = {{(DW-16){1'b0}}, w_half};
      default: w_load_aligned = r_load;
    endcase
  end

  // Writeback source select
  always_comb begin
    w_data = '0;
    case (r_wbsel)
      WBSEL_LOAD: w_data = w_load_aligned;
      WBSEL_ALU:  w_data = r_alu;
      WBSEL_PC4:  w_data = r_pc + DW'(4);
      default:    w_data = '0;
    endcase
  end

  // Write port: never issue a write to x0
  assign bus.RegWEn      = r_valid & r_regwen & (r_addrd != '0);
  assign bus.AddrD       = r_addrd;
  assign bus.DataD       = w_data;
  assign bus.WbValid     = r_valid;
  assign bus.RetireCount = r_retire_count;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table plus stall/flush, reset and wrap sequences.
module tb_wb_stage;

  logic clk;
  logic rst_n;

  wb_stage_if #(.WIDTH_ADDR_LENGTH(5), .WIDTH_DATA_LENGTH(32)) bus ();

  wb_stage #(.WIDTH_ADDR_LENGTH(5), .WIDTH_DATA_LENGTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regwen;
    logic [4:0]  addrd;
    logic [1:0]  wbsel;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] pc;
    logic        exp_regwen;
    logic [4:0]  exp_addrd;
    logic [31:0] exp_data;
    logic        exp_valid;
  } vec_t;

  int n_checks;
  int n_fail;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive Mem* fields at the falling edge
  task automatic drive(input logic valid, input logic regwen, input logic [4:0] addrd,
                       input logic [1:0] wbsel, input logic [2:0] funct3, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] load, input logic [31:0] pc);
    @(negedge clk);
    bus.MemValid    = valid;
    bus.MemRegWEn   = regwen;
    bus.MemAddrD    = addrd;
    bus.MemWBSel    = wbsel;
    bus.MemFunct3   = funct3;
    bus.MemByteOff  = off;
    bus.MemALUOut   = alu;
    bus.MemLoadData = load;
    bus.MemPC       = pc;
  endtask

  // Let one rising edge pass, tracking the expected retire count
  task automatic step();
    if (!bus.Flush && !bus.Stall && bus.MemValid) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 32'd0;
    rst_n    = 1'b0;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    bus.MemValid = 1'b0; bus.MemRegWEn = 1'b0; bus.MemAddrD = '0; bus.MemWBSel = '0;
    bus.MemFunct3 = '0; bus.MemByteOff = '0; bus.MemALUOut = '0; bus.MemLoadData = '0;
    bus.MemPC = '0;

    //          v  we  rd     sel   f3      off   alu            load           pc              ewe  erd    edata          ev
    vecs[0]  = '{1, 1, 5'd5,  2'd1, 3'b000, 2'd0, 32'h1234_5678, 32'h0,         32'h0,          1, 5'd5,  32'h1234_5678, 1};
    vecs[1]  = '{1, 1, 5'd6,  2'd2, 3'b000, 2'd0, 32'h0,         32'h0,         32'hFFFF_FFFC,  1, 5'd6,  32'h0000_0000, 1};
    vecs[2]  = '{1, 1, 5'd7,  2'd0, 3'b000, 2'd0, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd7,  32'hFFFF_FF81, 1};
    vecs[3]  = '{1, 1, 5'd7,  2'd0, 3'b100, 2'd0, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd7,  32'h0000_0081, 1};
    vecs[4]  = '{1, 1, 5'd7,  2'd0, 3'b000, 2'd1, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd7,  32'h0000_007F, 1};
    vecs[5]  = '{1, 1, 5'd7,  2'd0, 3'b001, 2'd2, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd7,  32'hFFFF_80FF, 1};
    vecs[6]  = '{1, 1, 5'd7,  2'd0, 3'b101, 2'd2, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd7,  32'h0000_80FF, 1};
    vecs[7]  = '{1, 1, 5'd7,  2'd0, 3'b010, 2'd3, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd7,  32'h80FF_7F81, 1};
    vecs[8]  = '{1, 1, 5'd8,  2'd0, 3'b000, 2'd3, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd8,  32'hFFFF_FF80, 1};
    vecs[9]  = '{1, 1, 5'd8,  2'd0, 3'b100, 2'd2, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd8,  32'h0000_00FF, 1};
    vecs[10] = '{1, 1, 5'd8,  2'd0, 3'b001, 2'd1, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd8,  32'h0000_7F81, 1};
    vecs[11] = '{1, 1, 5'd8,  2'd0, 3'b011, 2'd1, 32'h0,         32'h80FF_7F81, 32'h0,          1, 5'd8,  32'h80FF_7F81, 1};
    vecs[12] = '{1, 1, 5'd0,  2'd1, 3'b000, 2'd0, 32'h0000_0005, 32'h0,         32'h0,          0, 5'd0,  32'h0000_0005, 1};
    vecs[13] = '{1, 1, 5'd9,  2'd3, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0,         32'h0000_1000,  1, 5'd9,  32'h0000_0000, 1};
    vecs[14] = '{0, 1, 5'd10, 2'd1, 3'b000, 2'd0, 32'hCAFE_F00D, 32'h0,         32'h0,          0, 5'd10, 32'hCAFE_F00D, 0};
    vecs[15] = '{1, 0, 5'd11, 2'd2, 3'b000, 2'd0, 32'h0,         32'h0,         32'h0000_0100,  0, 5'd11, 32'h0000_0104, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwen", 32'(bus.RegWEn), 32'd0);
    chk("rst_addrd",  32'(bus.AddrD),  32'd0);
    chk("rst_data",   bus.DataD,       32'd0);
    chk("rst_valid",  32'(bus.WbValid), 32'd0);
    chk("rst_count",  bus.RetireCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].regwen, vecs[i].addrd, vecs[i].wbsel, vecs[i].funct3,
            vecs[i].off, vecs[i].alu, vecs[i].load, vecs[i].pc);
      step();
      chk($sformatf("v%0d_regwen", i), 32'(bus.RegWEn),  32'(vecs[i].exp_regwen));
      chk($sformatf("v%0d_addrd", i),  32'(bus.AddrD),   32'(vecs[i].exp_addrd));
      chk($sformatf("v%0d_data", i),   bus.DataD,        vecs[i].exp_data);
      chk($sformatf("v%0d_valid", i),  32'(bus.WbValid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_count", i),  bus.RetireCount,  exp_cnt);
    end
    chk("count_after_table", bus.RetireCount, 32'd15);

    // Stall holds the captured write while inputs change
    drive(1, 1, 5'd12, 2'd1, 3'b000, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 5'(13 + c), 2'd2, 3'b000, 2'd0, 32'h1111_0000 + 32'(c), 32'h0, 32'h2000);
      bus.Stall = 1'b1;
      step();
      chk($sformatf("stall%0d_regwen", c), 32'(bus.RegWEn), 32'd1);
      chk($sformatf("stall%0d_addrd", c),  32'(bus.AddrD),  32'd12);
      chk($sformatf("stall%0d_data", c),   bus.DataD,       32'hAAAA_5555);
      chk($sformatf("stall%0d_count", c),  bus.RetireCount, exp_cnt);
    end
    chk("stall_count_abs", bus.RetireCount, 32'd16);

    // Flush wins over stall
    @(negedge clk);
    bus.Flush = 1'b1;
    step();
    chk("flush_valid",  32'(bus.WbValid), 32'd0);
    chk("flush_regwen", 32'(bus.RegWEn),  32'd0);
    chk("flush_count",  bus.RetireCount,  32'd16);
    @(negedge clk);
    bus.Flush = 1'b0;
    bus.Stall = 1'b0;

    // Asynchronous reset mid-cycle with a write pending
    drive(1, 1, 5'd3, 2'd1, 3'b000, 2'd0, 32'h5A5A_A5A5, 32'h0, 32'h0);
    step();
    chk("pre_rst_regwen", 32'(bus.RegWEn), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_regwen", 32'(bus.RegWEn),  32'd0);
    chk("arst_valid",  32'(bus.WbValid), 32'd0);
    chk("arst_data",   bus.DataD,        32'd0);
    chk("arst_count",  bus.RetireCount,  32'd0);
    exp_cnt = 32'd0;
    drive(0, 0, 5'd0, 2'd0, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Counter wrap from all-ones
    @(negedge clk);
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_count;
    #1;
    chk("wrap_preload", bus.RetireCount, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    drive(1, 1, 5'd4, 2'd1, 3'b000, 2'd0, 32'h0000_0042, 32'h0, 32'h0);
    step();
    chk("wrap_count", bus.RetireCount, 32'd0);
    chk("wrap_data",  bus.DataD,       32'h0000_0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
